// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: opcode enum, flag/entry structs and
// the flag derivation applied to every captured result.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [SEL_W-1:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        AND  = 3'd2,
        OR   = 3'd3,
        XOR  = 3'd4,
        XNOR = 3'd5,
        NAND = 3'd6,
        NOR  = 3'd7
    } alu_sel_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic b;
    } alu_flags_t;

    typedef struct packed {
        alu_flags_t             flags;
        logic [SEL_W-1:0]       sel;
        logic [DATA_W-1:0]      data;
    } alu_entry_t;

    localparam int ENTRY_W = $bits(alu_entry_t);

    // CarryOut only means something for ADD (carry) and SUB (borrow).
    function automatic alu_flags_t derive_flags(input logic [DATA_W-1:0] data,
                                                input logic              carry,
                                                input logic [SEL_W-1:0]  sel);
        alu_flags_t f;
        f.n = data[DATA_W-1];
        f.z = (data == {DATA_W{1'b0}});
        f.c = (sel == ADD) ? carry : 1'b0;
        f.b = (sel == SUB) ? carry : 1'b0;
        return f;
    endfunction

endpackage

// File: rtl/alu_result_queue_if.sv
// Producer (ALU) and consumer handshake bundle of the ALU result queue.
interface alu_result_queue_if
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] alu_out;
    logic              alu_carry;
    logic [SEL_W-1:0]  alu_sel;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [SEL_W-1:0]  out_sel;
    logic [3:0]        out_flags;
    logic [LVL_W-1:0]  level;
    logic [15:0]       res_cnt;

    modport master (
        output in_valid, alu_out, alu_carry, alu_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_flags, level, res_cnt
    );

    modport slave (
        input  in_valid, alu_out, alu_carry, alu_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_flags, level, res_cnt
    );

endinterface

// File: rtl/alu_sync_fifo.sv
// Generic synchronous FIFO with level tracking and a registered show-ahead head,
// so the read side never sees a combinational path from the write side.
module alu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_nxt_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_nxt_s;
    logic             push_s;
    logic             pop_s;

    assign wr_ready = (level_r != LVL_W'(DEPTH));
    assign rd_valid = (level_r != {LVL_W{1'b0}});
    assign push_s   = wr_valid & wr_ready;
    assign pop_s    = rd_valid & rd_ready;
    assign rd_data  = head_r;
    assign level    = level_r;

    // Next read pointer, level and head value; an empty result keeps the old head.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        level_nxt_s  = level_r;
        head_nxt_s   = head_r;
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
        if (level_nxt_s == {LVL_W{1'b0}}) begin
            head_nxt_s = head_r;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = wr_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, level and head register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            head_r   <= {WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r <= rd_ptr_nxt_s;
            level_r  <= level_nxt_s;
            head_r   <= head_nxt_s;
        end
    end

endmodule

// File: rtl/alu_result_queue.sv
// Captures ALU results with derived flags into a small FIFO and presents them
// to a possibly stalling consumer; also counts accepted results.
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_result_queue_if.slave  bus
);

    localparam int LVL_W = $clog2(DEPTH) + 1;

    alu_entry_t       entry_in_s;
    alu_entry_t       entry_out_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic [LVL_W-1:0] level_s;
    logic             push_s;
    logic [15:0]      res_cnt_r;

    // Pack the incoming result with its flags.
    always_comb begin
        entry_in_s       = '{flags: 4'b0000, sel: {SEL_W{1'b0}}, data: {DATA_W{1'b0}}};
        entry_in_s.flags = derive_flags(bus.alu_out, bus.alu_carry, bus.alu_sel);
        entry_in_s.sel   = bus.alu_sel;
        entry_in_s.data  = bus.alu_out;
    end

    alu_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_valid (bus.in_valid),
        .wr_ready (in_ready_s),
        .wr_data  (entry_in_s),
        .rd_valid (out_valid_s),
        .rd_ready (bus.out_ready),
        .rd_data  (entry_out_s),
        .level    (level_s)
    );

    assign push_s = bus.in_valid & in_ready_s;

    // Accepted-result counter, wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_cnt_r <= 16'h0000;
        end else if (push_s) begin
            res_cnt_r <= res_cnt_r + 16'h0001;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_s;
    assign bus.out_data  = entry_out_s.data;
    assign bus.out_sel   = entry_out_s.sel;
    assign bus.out_flags = entry_out_s.flags;
    assign bus.level     = level_s;
    assign bus.res_cnt   = res_cnt_r;

endmodule

// File: tb/tb_alu_result_queue.sv
// Randomized self-checking bench for alu_result_queue against a queue-based model.
module tb_alu_result_queue;

    localparam int DEPTH = 4;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    logic [14:0] mq[$];
    logic [14:0] last_e;
    int          cnt;

    alu_result_queue_if #(.DEPTH(DEPTH)) bus ();

    alu_result_queue #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] mk(input logic [7:0] d, input logic cy, input logic [2:0] s);
        logic n, z, c, b;
        n = (d >= 8'd128);
        z = (d == 8'd0);
        c = (s == 3'd0) && cy;
        b = (s == 3'd1) && cy;
        return {n, z, c, b, s, d};
    endfunction

    // One clock: model follows the handshake rules on pre-edge inputs; ends at negedge.
    task automatic tick();
        bit push, pop;
        logic [14:0] e;
        push = bus.in_valid && (mq.size() < DEPTH);
        pop  = bus.out_ready && (mq.size() > 0);
        e    = mk(bus.alu_out, bus.alu_carry, bus.alu_sel);
        @(posedge clk);
        if (pop) last_e = mq.pop_front();
        if (push) begin
            mq.push_back(e);
            cnt = (cnt + 1) % 65536;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.alu_out   = 8'h00;
        bus.alu_carry = 1'b0;
        bus.alu_sel   = 3'd0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        mq.delete();
        cnt    = 0;
        last_e = 15'h0000;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({bus.out_valid, bus.in_ready, bus.level} !== {1'b0, 1'b1, 3'd0}) begin
            n_errors++;
            $display("FAIL reset_ctrl got v=%0b r=%0b lvl=%0d exp v=0 r=1 lvl=0", bus.out_valid, bus.in_ready, bus.level);
        end
        n_checks++;
        if (bus.res_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_cnt got %0d exp 0", bus.res_cnt);
        end
        n_checks++;
        if ({bus.out_flags, bus.out_sel, bus.out_data} !== 15'h0000) begin
            n_errors++;
            $display("FAIL reset_head got %h exp 0", {bus.out_flags, bus.out_sel, bus.out_data});
        end
    endtask

    task automatic test_add_flags();
        bus.in_valid = 1'b1; bus.alu_out = 8'h00; bus.alu_carry = 1'b1; bus.alu_sel = 3'd0;
        bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.out_data, bus.out_flags} !== {1'b1, 8'h00, 4'b0110}) begin
            n_errors++;
            $display("FAIL add_flags got v=%0b d=%h f=%b exp v=1 d=00 f=0110", bus.out_valid, bus.out_data, bus.out_flags);
        end
        tick();
        n_checks++;
        if ({bus.out_valid, bus.level} !== {1'b0, 3'd0}) begin
            n_errors++;
            $display("FAIL add_pop got v=%0b lvl=%0d exp v=0 lvl=0", bus.out_valid, bus.level);
        end
    endtask

    task automatic test_sub_logic();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.alu_out = 8'hFE; bus.alu_carry = 1'b1; bus.alu_sel = 3'd1;
        tick();
        bus.alu_out = 8'h80; bus.alu_carry = 1'b1; bus.alu_sel = 3'd2;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_flags, bus.out_sel, bus.out_data} !== {4'b1001, 3'd1, 8'hFE}) begin
            n_errors++;
            $display("FAIL sub_borrow got f=%b s=%0d d=%h exp f=1001 s=1 d=fe", bus.out_flags, bus.out_sel, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if ({bus.out_flags, bus.out_sel, bus.out_data} !== {4'b1000, 3'd2, 8'h80}) begin
            n_errors++;
            $display("FAIL logic_mask got f=%b s=%0d d=%h exp f=1000 s=2 d=80", bus.out_flags, bus.out_sel, bus.out_data);
        end
        tick();
        n_checks++;
        if (bus.level !== 3'd0) begin
            n_errors++;
            $display("FAIL sub_drain got lvl=%0d exp 0", bus.level);
        end
    endtask

    task automatic test_fill_backpressure();
        int idx, got;
        bit acc;
        apply_reset();
        idx = 1;
        bus.out_ready = 1'b0;
        bus.alu_carry = 1'b0; bus.alu_sel = 3'd2;
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1; bus.alu_out = idx[7:0];
            acc = bus.in_ready;
            tick();
            if (acc) idx++;
        end
        n_checks++;
        if ({bus.level, bus.in_ready, idx[7:0]} !== {3'd4, 1'b0, 8'd5}) begin
            n_errors++;
            $display("FAIL fill_full got lvl=%0d rdy=%0b next=%0d exp lvl=4 rdy=0 next=5", bus.level, bus.in_ready, idx);
        end
        bus.out_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && got < 5; k++) begin
            if (bus.out_valid) begin
                n_checks++;
                if (bus.out_data !== 8'(got + 1)) begin
                    n_errors++;
                    $display("FAIL fill_order got %h exp %h", bus.out_data, 8'(got + 1));
                end
                got++;
            end
            acc = bus.in_ready && bus.in_valid;
            tick();
            if (acc) idx++;
            if (idx > 5) bus.in_valid = 1'b0;
            else bus.alu_out = idx[7:0];
        end
        n_checks++;
        if (got != 5 || bus.res_cnt !== 16'd5) begin
            n_errors++;
            $display("FAIL fill_count got items=%0d res_cnt=%0d exp items=5 res_cnt=5", got, bus.res_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bus.in_valid = 1'b1; bus.alu_out = 8'($urandom); bus.alu_carry = 1'($urandom); bus.alu_sel = 3'($urandom);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            bus.alu_out = 8'($urandom); bus.alu_carry = 1'($urandom); bus.alu_sel = 3'($urandom);
            n_checks++;
            if (bus.level !== 3'(mq.size()) || bus.level !== 3'd2 ||
                {bus.out_flags, bus.out_sel, bus.out_data} !== mq[0]) begin
                n_errors++;
                $display("FAIL b2b got lvl=%0d head=%h exp lvl=2 head=%h", bus.level, {bus.out_flags, bus.out_sel, bus.out_data}, mq[0]);
            end
            tick();
        end
        bus.out_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.level, bus.in_ready} !== {3'd4, 1'b0}) begin
            n_errors++;
            $display("FAIL b2b_full got lvl=%0d rdy=%0b exp lvl=4 rdy=0", bus.level, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.level !== 3'd3) begin
            n_errors++;
            $display("FAIL b2b_full_pop got lvl=%0d exp 3", bus.level);
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8 && mq.size() > 0; k++) tick();
    endtask

    task automatic test_random();
        logic [14:0] exp_head;
        for (int k = 0; k < 400; k++) begin
            bus.in_valid  = ($urandom_range(0, 99) < 60);
            bus.out_ready = ($urandom_range(0, 99) < 50);
            bus.alu_out   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            bus.alu_carry = 1'($urandom);
            bus.alu_sel   = 3'($urandom);
            tick();
            exp_head = (mq.size() > 0) ? mq[0] : last_e;
            n_checks++;
            if ({bus.out_valid, bus.in_ready, bus.level} !== {mq.size() != 0, mq.size() < DEPTH, 3'(mq.size())} ||
                bus.res_cnt !== 16'(cnt) || {bus.out_flags, bus.out_sel, bus.out_data} !== exp_head) begin
                n_errors++;
                $display("FAIL random cyc=%0d got v=%0b r=%0b lvl=%0d cnt=%0d head=%h exp lvl=%0d cnt=%0d head=%h",
                         k, bus.out_valid, bus.in_ready, bus.level, bus.res_cnt,
                         {bus.out_flags, bus.out_sel, bus.out_data}, mq.size(), cnt, exp_head);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_midop_reset();
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 8 && mq.size() > 0; k++) begin
            bus.out_ready = 1'b1;
            tick();
        end
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1; bus.alu_out = 8'($urandom); bus.alu_sel = 3'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.level !== 3'd3) begin
            n_errors++;
            $display("FAIL midrst_pre got lvl=%0d exp 3", bus.level);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.level} !== {1'b0, 3'd0}) begin
            n_errors++;
            $display("FAIL midrst_async got v=%0b lvl=%0d exp v=0 lvl=0", bus.out_valid, bus.level);
        end
        @(negedge clk);
        reset_n = 1'b1;
        mq.delete(); cnt = 0; last_e = 15'h0000;
        bus.in_valid = 1'b1; bus.alu_out = 8'h5A; bus.alu_carry = 1'b1; bus.alu_sel = 3'd3;
        tick();
        bus.in_valid = 1'b0;
        n_checks++;
        if ({bus.out_valid, bus.res_cnt, bus.out_data, bus.out_flags} !== {1'b1, 16'd1, 8'h5A, 4'b0000}) begin
            n_errors++;
            $display("FAIL midrst_post got v=%0b cnt=%0d d=%h f=%b exp v=1 cnt=1 d=5a f=0000",
                     bus.out_valid, bus.res_cnt, bus.out_data, bus.out_flags);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        test_add_flags();
        test_sub_logic();
        test_fill_backpressure();
        test_back_to_back();
        test_random();
        test_midop_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
